ppi_port_conditioner: RTL and testbench
=======================================

Name: ppi_port_conditioner

Overview:
Parametrised pad-side front end for the KF8255 PPI core and its future multi-port variants. It handles N ports of W bits each. Per port it provides:
- pad tri-state control;
- a multi-stage input synchroniser;
- per-port change detection;
- an 8255 mode-1 style strobed input latch with input-buffer-full (IBF) and overrun flags.

It sits between the chip pads and the PPI core's port_*_in / port_*_out / port_*_io signals.

Parameters:
PORT_COUNT, 3, number of ports (legal 1..8)
PORT_WIDTH, 8, bits per port (legal 1..16)
SYNC_STAGES, 2, input synchroniser depth (legal 2..4)
FILTER_CYCLES, 3, stable-sample count for the input filter; used only with the optional feature (legal 1..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pad_in  in  PORT_COUNT*PORT_WIDTH  raw pad levels; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH]
core_out  in  PORT_COUNT*PORT_WIDTH  output data from the PPI core
core_io  in  PORT_COUNT*PORT_WIDTH  per-bit direction from the core; 1 = input, 0 = output
latch_mode  in  PORT_COUNT  1 = strobed-latch input mode, 0 = transparent input mode
strobe_n  in  PORT_COUNT  asynchronous active-low strobe from the peripheral
read_ack  in  PORT_COUNT  one-cycle pulse: the core has read the port
pad_out  out  PORT_COUNT*PORT_WIDTH  pad drive value
pad_oe  out  PORT_COUNT*PORT_WIDTH  pad output enable, active high
core_in  out  PORT_COUNT*PORT_WIDTH  conditioned input data to the core
ibf  out  PORT_COUNT  input buffer full
overrun  out  PORT_COUNT  strobe arrived while ibf was set
change  out  PORT_COUNT  one-cycle pulse: an input-direction bit changed

Behaviour:
Clocking and reset
- All flops update on the falling edge of clock, matching the KF8255 core sampling edge.
- reset asserts asynchronously.
- While reset is high and on release, all state is 0: sync chains, strobe sync, core_in, ibf, overrun, change, and the filter state.
- pad_out and pad_oe are combinational and are not affected by reset.

Pad drive
- pad_out = core_out.
- pad_oe[i] = ~core_io[i].
- Zero latency.

Synchroniser
- pad_in and strobe_n each pass through SYNC_STAGES flops.
- sync_data = last stage; sync_stb = last strobe stage.
- prev_stb holds the value of sync_stb from the previous edge.

Transparent mode (latch_mode[p] = 0)
- core_in[p] <= sync_data[p] every edge.
- Pad-to-core_in latency = SYNC_STAGES + 1 falling edges.
- ibf[p] and overrun[p] are held at 0.

Latched mode (latch_mode[p] = 1)
- Strobe event: prev_stb = 1 and sync_stb = 0.
- Strobe event with ibf = 0: core_in[p] <= sync_data[p]; ibf <= 1.
- Strobe event with ibf = 1: core_in is unchanged; overrun <= 1.
- read_ack[p] = 1: ibf <= 0 and overrun <= 0.
- read_ack and strobe event on the same edge: the acknowledge is applied first, then the capture. Result: ibf = 1, new data in core_in, overrun = 0.
- read_ack while ibf = 0: no effect.
- latch_mode 1 -> 0: ibf and overrun clear on the next edge; transparent tracking resumes on that edge.
- latch_mode 0 -> 1: core_in holds its last transparent value; ibf = 0.

Change detect
- change[p] = 1 for one edge when (sync_data[p] XOR previous sync_data[p]) AND core_io[p] is non-zero.
- Bits configured as outputs never generate change.
- The first edge after reset compares against 0.

State per port
- IDLE (ibf = 0) -> FULL on strobe event.
- FULL -> IDLE on read_ack without a strobe event.
- FULL -> FULL with overrun set on a strobe event without read_ack.
- Any state -> IDLE on latch_mode = 0 or on reset.

Optional Feature:
Macro: PPI_INPUT_FILTER_EN

Defined:
- Each port has a 4-bit stability counter after the synchroniser.
- The counter reloads to 0 whenever sync_data[p] differs from its previous value.
- Otherwise it counts up, saturating at FILTER_CYCLES.
- filt_data[p] <= sync_data[p] only when the counter reaches FILTER_CYCLES.
- filt_data replaces sync_data in transparent mode, latched capture and change detect.
- This adds FILTER_CYCLES edges of latency. Pulses shorter than FILTER_CYCLES edges are rejected.
- The strobe path is not filtered.

Undefined:
- No counters exist; sync_data is used directly.
- FILTER_CYCLES is ignored.

Test Plan:
1. Pad drive: PORT_COUNT = 3, core_io port B = 8'h0F, core_out B = 8'hA5 -> pad_oe B = 8'hF0, pad_out B = 8'hA5 immediately. Reset asserted -> both unchanged.
2. Transparent latency: port A input, pad_in A 8'h00 -> 8'h3C with SYNC_STAGES = 2 -> core_in A = 8'h3C exactly 3 falling edges later; change[0] pulses for exactly one edge.
3. Latched capture and overrun:
   - latch_mode[2] = 1, pad C = 8'h81, strobe_n low for 4 cycles -> core_in C = 8'h81, ibf[2] = 1.
   - pad C = 8'h42, second strobe -> core_in C stays 8'h81, overrun[2] = 1.
   - read_ack[2] -> ibf[2] = 0, overrun[2] = 0.
4. Simultaneous events: ibf[0] = 1, strobe event with pad 8'h55 on the same edge as read_ack[0] -> ibf[0] = 1, core_in A = 8'h55, overrun[0] = 0.
5. Reset mid-operation: ibf = 1, overrun = 1, core_in = 8'hFF; pulse reset between clock edges -> all cleared asynchronously without a clock edge. After release with pad = 8'h00, no change pulse.
6. Filter (PPI_INPUT_FILTER_EN, FILTER_CYCLES = 3):
   - 2-edge glitch 8'h00 -> 8'h01 -> 8'h00 -> core_in stays 8'h00 and no change pulse.
   - Steady 8'h01 -> core_in = 8'h01 after SYNC_STAGES + 3 + 1 edges.

Source files
------------

// File: rtl/ppi_port_conditioner.sv
// ppi_port_conditioner: pad tri-state, input sync, change detect and strobed latch per port.
// Optional input stability filter enabled by defining PPI_INPUT_FILTER_EN.
module ppi_port_conditioner #(
    parameter int PORT_COUNT    = 3,
    parameter int PORT_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PORT_COUNT*PORT_WIDTH-1:0] pad_in,
    input  logic [PORT_COUNT*PORT_WIDTH-1:0] core_out,
    input  logic [PORT_COUNT*PORT_WIDTH-1:0] core_io,
    input  logic [PORT_COUNT-1:0]            latch_mode,
    input  logic [PORT_COUNT-1:0]            strobe_n,
    input  logic [PORT_COUNT-1:0]            read_ack,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pad_out,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pad_oe,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] core_in,
    output logic [PORT_COUNT-1:0]            ibf,
    output logic [PORT_COUNT-1:0]            overrun,
    output logic [PORT_COUNT-1:0]            change
);
    localparam int N = PORT_COUNT * PORT_WIDTH;
    localparam int W = PORT_WIDTH;

    logic [SYNC_STAGES-1:0][N-1:0]          data_sync;
    logic [SYNC_STAGES-1:0][PORT_COUNT-1:0] stb_sync;
    logic [N-1:0]                           sync_data, in_data, prev_in;
    logic [PORT_COUNT-1:0]                  sync_stb, prev_stb;

    assign pad_out   = core_out;
    assign pad_oe    = ~core_io;
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign sync_stb  = stb_sync[SYNC_STAGES-1];

    always_ff @(negedge clock or posedge reset)
        if (reset) begin
            data_sync <= '0;
            stb_sync  <= '0;
            prev_stb  <= '0;
            prev_in   <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], pad_in};
            stb_sync  <= {stb_sync[SYNC_STAGES-2:0], strobe_n};
            prev_stb  <= sync_stb;
            prev_in   <= in_data;
        end

`ifdef PPI_INPUT_FILTER_EN
    localparam logic [3:0] FC = 4'(FILTER_CYCLES);
    logic [PORT_COUNT-1:0][3:0] cnt;
    for (genvar f = 0; f < PORT_COUNT; f++) begin : g_filt
        logic       diff;
        logic [3:0] cnt_next;
        // Look one stage ahead so the reload lands on the edge sync_data itself changes
        assign diff     = data_sync[SYNC_STAGES-2][f*W +: W] != sync_data[f*W +: W];
        assign cnt_next = diff ? 4'd0 : (cnt[f] == FC ? cnt[f] : cnt[f] + 4'd1);
        always_ff @(negedge clock or posedge reset)
            if (reset) begin
                cnt[f]           <= '0;
                in_data[f*W +: W] <= '0;
            end else begin
                cnt[f] <= cnt_next;
                if (cnt_next == FC)
                    in_data[f*W +: W] <= sync_data[f*W +: W];
            end
    end
`else
    assign in_data = sync_data;
`endif

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        logic evt;
        assign evt = prev_stb[p] & ~sync_stb[p];
        always_ff @(negedge clock or posedge reset)
            if (reset) begin
                core_in[p*W +: W] <= '0;
                ibf[p]            <= 1'b0;
                overrun[p]        <= 1'b0;
                change[p]         <= 1'b0;
            end else begin
                change[p] <= |((in_data[p*W +: W] ^ prev_in[p*W +: W]) & core_io[p*W +: W]);
                if (!latch_mode[p]) begin
                    core_in[p*W +: W] <= in_data[p*W +: W];
                    ibf[p]            <= 1'b0;
                    overrun[p]        <= 1'b0;
                end else begin
                    // Acknowledge is applied before capture on a coincident edge
                    if (evt && (!ibf[p] || read_ack[p]))
                        core_in[p*W +: W] <= in_data[p*W +: W];
                    ibf[p]     <= evt | (ibf[p] & ~read_ack[p]);
                    overrun[p] <= ~read_ack[p] & (overrun[p] | (evt & ibf[p]));
                end
            end
    end
endmodule

// File: tb/tb_ppi_port_conditioner.sv
// tb_ppi_port_conditioner: directed checks of pad drive, sync latency, latch, change and reset.
module tb_ppi_port_conditioner;
    localparam int P = 3;
    localparam int N = 24;
`ifdef PPI_INPUT_FILTER_EN
    localparam int FL = 3;
`else
    localparam int FL = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pad_in, core_out, core_io, pad_out, pad_oe, core_in;
    logic [P-1:0] latch_mode, strobe_n, read_ack, ibf, overrun, change, acc;
    int           tests = 0, fails = 0;

    ppi_port_conditioner dut (
        .clock(clock), .reset(reset), .pad_in(pad_in), .core_out(core_out),
        .core_io(core_io), .latch_mode(latch_mode), .strobe_n(strobe_n),
        .read_ack(read_ack), .pad_out(pad_out), .pad_oe(pad_oe), .core_in(core_in),
        .ibf(ibf), .overrun(overrun), .change(change)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic watch(input int n, output logic [P-1:0] a);
        a = '0;
        repeat (n) begin
            @(posedge clock);
            a |= change;
        end
    endtask

    task automatic pulse_stb(input int p);
        strobe_n[p] = 1'b0;
        step(4);
        strobe_n[p] = 1'b1;
        step(3);
    endtask

    initial begin
        pad_in = '0; core_out = '0; core_io = '1;
        latch_mode = '0; strobe_n = '1; read_ack = '0;
        step(2);
        check("rst_core_in", core_in, 0);
        check("rst_ibf", ibf, 0);
        check("rst_overrun", overrun, 0);
        check("rst_change", change, 0);

        core_io = 24'hFF0FFF;
        core_out = 24'h00A500;
        #1;
        check("oe_in_reset", pad_oe[15:8], 8'hF0);
        check("out_in_reset", pad_out[15:8], 8'hA5);
        step(1);
        reset = 1'b0;
        check("oe_after_rst", pad_oe[15:8], 8'hF0);
        watch(4, acc);
        check("idle_change", acc, 0);

        pad_in[7:0] = 8'h3C;
        for (int i = 0; i < 2 + FL; i++) begin
            step(1);
            check("lat_early", core_in[7:0], 8'h00);
        end
        step(1);
        check("lat_exact", core_in[7:0], 8'h3C);
        check("chg_pulse", change, 3'b001);
        step(1);
        check("chg_one_edge", change, 3'b000);

        pad_in[15:8] = 8'hF0;
        watch(4 + FL, acc);
        check("chg_out_bits", acc, 0);
        pad_in[15:8] = 8'hF1;
        step(3 + FL);
        check("chg_in_bit", change, 3'b010);

        latch_mode[2] = 1'b1;
        pad_in[23:16] = 8'h81;
        step(3 + FL);
        check("latch_hold", core_in[23:16], 8'h00);
        pulse_stb(2);
        check("cap_data", core_in[23:16], 8'h81);
        check("cap_ibf", ibf, 3'b100);
        check("cap_no_ovr", overrun, 3'b000);
        pad_in[23:16] = 8'h42;
        step(3 + FL);
        pulse_stb(2);
        check("ovr_data", core_in[23:16], 8'h81);
        check("ovr_flag", overrun, 3'b100);
        check("ovr_ibf", ibf, 3'b100);
        read_ack[2] = 1'b1;
        step(1);
        read_ack[2] = 1'b0;
        check("ack_ibf", ibf, 3'b000);
        check("ack_ovr", overrun, 3'b000);

        latch_mode[0] = 1'b1;
        pad_in[7:0] = 8'h11;
        step(3 + FL);
        pulse_stb(0);
        check("a_cap", core_in[7:0], 8'h11);
        pad_in[7:0] = 8'h55;
        step(3 + FL);
        strobe_n[0] = 1'b0;
        step(2);
        read_ack[0] = 1'b1;
        step(1);
        read_ack[0] = 1'b0;
        check("sim_ibf", ibf[0], 1'b1);
        check("sim_data", core_in[7:0], 8'h55);
        check("sim_ovr", overrun[0], 1'b0);
        strobe_n[0] = 1'b1;
        step(3);
        latch_mode[0] = 1'b0;
        step(1);
        check("unlatch_ibf", ibf[0], 1'b0);

        pad_in[23:16] = 8'hFF;
        step(3 + FL);
        pulse_stb(2);
        pulse_stb(2);
        check("pre_ibf", ibf[2], 1'b1);
        check("pre_ovr", overrun[2], 1'b1);
        check("pre_data", core_in[23:16], 8'hFF);
        pad_in = '0;
        #2 reset = 1'b1;
        #1;
        check("arst_core_in", core_in, 0);
        check("arst_ibf", ibf, 0);
        check("arst_ovr", overrun, 0);
        check("arst_oe", pad_oe[15:8], 8'hF0);
        #1 reset = 1'b0;
        watch(6 + FL, acc);
        check("post_rst_chg", acc, 0);

`ifdef PPI_INPUT_FILTER_EN
        pad_in[7:0] = 8'h01;
        step(2);
        pad_in[7:0] = 8'h00;
        watch(10, acc);
        check("glitch_chg", acc, 0);
        check("glitch_data", core_in[7:0], 8'h00);
        pad_in[7:0] = 8'h01;
        step(5);
        check("filt_early", core_in[7:0], 8'h00);
        step(1);
        check("filt_data", core_in[7:0], 8'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
